// File: rtl/big_split_nway.sv
// big_split_nway
//
// Joins a data token with a destination select (ctl_sel) and a core/network
// select (core_sel).  Each token goes to exactly one place: the local core
// FIFO, one of NUM_OUT network port FIFOs, or it is dropped and counted.
// Every destination has its own DEPTH-entry FIFO, so a stalled port only
// blocks the input join while the token at the head of the input is
// addressed to it.
//
// Ports
//   clk, reset                     single clock, synchronous active-high reset
//   in_data/in_valid/in_ready      data channel
//   ctl_sel/ctl_valid/ctl_ready    destination port index
//   core_sel/core_valid/core_ready 1 = local core, 0 = network port
//   out_data/out_valid/out_ready   network ports, port p at [p*WIDTH +: WIDTH]
//   core_out_*                     local core port
//   drop_cnt                       saturating count of illegal-select drops

module big_split_nway #(
    parameter int WIDTH   = 11,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         ctl_sel,
    input  logic                     ctl_valid,
    output logic                     ctl_ready,
    input  logic                     core_sel,
    input  logic                     core_valid,
    output logic                     core_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [WIDTH-1:0]         core_out_data,
    output logic                     core_out_valid,
    input  logic                     core_out_ready,
    output logic [7:0]               drop_cnt
);

    // Destination index NUM_OUT is the local core FIFO.
    localparam int NDEST = NUM_OUT + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [NDEST-1:0]            tgt;
    logic [NDEST-1:0]            can_push;
    logic [NDEST-1:0]            push;
    logic [NDEST-1:0]            pop;
    logic [NDEST-1:0]            fifo_valid;
    logic [NDEST-1:0]            dest_ready;
    logic [NDEST-1:0][WIDTH-1:0] head_data;
    logic                        is_drop;
    logic                        all_valid;
    logic                        fire;

    assign dest_ready = {core_out_ready, out_ready};
    assign pop        = fifo_valid & dest_ready;

    // One-hot resolved destination; all zeros means the select is illegal.
    always_comb begin
        tgt = '0;
        if (core_sel) begin
            tgt[NUM_OUT] = 1'b1;
        end else begin
            for (int p = 0; p < NUM_OUT; p++) begin
                if (ctl_sel == SEL_W'(p)) begin
                    tgt[p] = 1'b1;
                end
            end
        end
    end

    assign is_drop   = (tgt == '0);
    assign all_valid = in_valid & ctl_valid & core_valid & ~reset;
    // Drops never wait on FIFO space.
    assign fire      = all_valid & (is_drop | (|(tgt & can_push)));
    assign push      = {NDEST{fire}} & tgt;

    assign in_ready   = fire;
    assign ctl_ready  = fire;
    assign core_ready = fire;

    for (genvar d = 0; d < NDEST; d++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    count;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[d]) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop[d]) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                case ({push[d], pop[d]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[d]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        assign fifo_valid[d] = (count != '0);
        // A full FIFO still takes a token when its head leaves this cycle.
        assign can_push[d]   = (count != CW'(DEPTH)) | pop[d];
        // Empty FIFOs present zero so nothing stale is ever visible.
        assign head_data[d]  = fifo_valid[d] ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (fire && is_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign out_data       = head_data[NUM_OUT-1:0];
    assign out_valid      = fifo_valid[NUM_OUT-1:0];
    assign core_out_data  = head_data[NUM_OUT];
    assign core_out_valid = fifo_valid[NUM_OUT];

endmodule

// File: tb/tb_big_split_nway.sv
module tb_big_split_nway;

    localparam int WIDTH   = 11;
    localparam int NUM_OUT = 3;
    localparam int SEL_W   = 2;
    localparam int DEPTH   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         ctl_sel;
    logic                     ctl_valid;
    logic                     ctl_ready;
    logic                     core_sel;
    logic                     core_valid;
    logic                     core_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [WIDTH-1:0]         core_out_data;
    logic                     core_out_valid;
    logic                     core_out_ready;
    logic [7:0]               drop_cnt;

    big_split_nway #(
        .WIDTH  (WIDTH),
        .NUM_OUT(NUM_OUT),
        .SEL_W  (SEL_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ctl_sel       (ctl_sel),
        .ctl_valid     (ctl_valid),
        .ctl_ready     (ctl_ready),
        .core_sel      (core_sel),
        .core_valid    (core_valid),
        .core_ready    (core_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .core_out_data (core_out_data),
        .core_out_valid(core_out_valid),
        .core_out_ready(core_out_ready),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per destination (index NUM_OUT = core).
    logic [WIDTH-1:0] mq [NUM_OUT+1][$];
    int               drops = 0;

    logic [2:0]                   obs_rdy, exp_rdy;
    logic [NUM_OUT:0]             obs_vld, exp_vld;
    logic [(NUM_OUT+1)*WIDTH-1:0] obs_dat, exp_dat;
    logic [7:0]                   obs_drop, exp_drop;

    // Advances one clock: samples the DUT mid-cycle, predicts the same
    // quantities from the model, then applies the clock edge to the model.
    task automatic tick();
        int               d;
        bit               fire;
        logic [NUM_OUT:0] rdy;
        @(negedge clk);
        rdy = {core_out_ready, out_ready};
        if (core_sel)                  d = NUM_OUT;
        else if (int'(ctl_sel) < NUM_OUT) d = int'(ctl_sel);
        else                           d = -1;
        fire = !reset && in_valid && ctl_valid && core_valid &&
               (d < 0 || mq[d].size() < DEPTH || (mq[d].size() > 0 && rdy[d]));
        exp_rdy = {3{fire}};
        for (int k = 0; k <= NUM_OUT; k++) begin
            exp_vld[k] = (mq[k].size() > 0);
            exp_dat[k*WIDTH +: WIDTH] = exp_vld[k] ? mq[k][0] : '0;
        end
        exp_drop = 8'(drops);
        obs_rdy  = {in_ready, ctl_ready, core_ready};
        obs_vld  = {core_out_valid, out_valid};
        obs_dat  = {core_out_data, out_data};
        for (int k = 0; k <= NUM_OUT; k++)
            if (!exp_vld[k]) obs_dat[k*WIDTH +: WIDTH] = '0;
        obs_drop = drop_cnt;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k <= NUM_OUT; k++) mq[k].delete();
            drops = 0;
        end else begin
            for (int k = 0; k <= NUM_OUT; k++)
                if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
            if (fire) begin
                if (d < 0) drops = (drops < 255) ? drops + 1 : 255;
                else       mq[d].push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; ctl_valid = 0; core_valid = 0;
        in_data = '0; ctl_sel = '0; core_sel = 0;
        out_ready = '1; core_out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1; ctl_valid = 1; core_valid = 1; in_data = 11'h3AA;
        reset = 1;
        tick();
        checks++;
        if (obs_rdy !== 3'b000) begin
            errors++; $display("FAIL reset_ready got=%b exp=000", obs_rdy);
        end
        tick();
        checks += 4;
        if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL reset ready got=%b exp=%b", obs_rdy, exp_rdy); end
        if (obs_vld !== exp_vld) begin errors++; $display("FAIL reset valid got=%b exp=%b", obs_vld, exp_vld); end
        if (obs_dat !== exp_dat) begin errors++; $display("FAIL reset data got=%h exp=%h", obs_dat, exp_dat); end
        if (obs_drop !== exp_drop) begin errors++; $display("FAIL reset drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
        checks += 2;
        if ({core_out_valid, out_valid} !== '0) begin
            errors++; $display("FAIL reset_valids got=%b exp=0", {core_out_valid, out_valid});
        end
        if (drop_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
        end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_port_route();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 0) begin
                in_valid = 1; ctl_valid = 1; core_valid = 1;
                ctl_sel = 2; core_sel = 0; in_data = 11'h155;
            end
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL port ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL port valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL port data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL port drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            checks++;
            if (obs_vld !== ((i == 1) ? 4'b0100 : 4'b0000)) begin
                errors++; $display("FAIL port_latency cycle=%0d got=%b", i, obs_vld);
            end
        end
        checks++;
        if (obs_dat[2*WIDTH +: WIDTH] !== '0) begin
            errors++; $display("FAIL port_gone got=%h exp=0", obs_dat[2*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_core_route();
        logic [WIDTH-1:0] seen;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 0) begin
                in_valid = 1; ctl_valid = 1; core_valid = 1;
                ctl_sel = 3; core_sel = 1; in_data = 11'h7FF;
            end
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL core ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL core valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL core data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL core drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            if (i == 1) seen = obs_dat[NUM_OUT*WIDTH +: WIDTH];
            checks++;
            if (obs_vld[NUM_OUT-1:0] !== '0) begin
                errors++; $display("FAIL core_no_net got=%b exp=0", obs_vld[NUM_OUT-1:0]);
            end
        end
        checks++;
        if (seen !== 11'h7FF) begin
            errors++; $display("FAIL core_data got=%h exp=7ff", seen);
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] toks [3];
        logic [WIDTH-1:0] seen [$];
        int idx = 0;
        toks[0] = 11'h101; toks[1] = 11'h202; toks[2] = 11'h303;
        idle_inputs();
        out_ready = 3'b101;
        in_valid = 1; ctl_valid = 1; core_valid = 1; ctl_sel = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = toks[idx];
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL stall ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL stall valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL stall data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL stall drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            checks++;
            if (obs_rdy !== {3{i < 2}}) begin
                errors++; $display("FAIL stall_join cycle=%0d got=%b", i, obs_rdy);
            end
            if (exp_rdy[0]) idx++;
        end
        out_ready = 3'b111;
        for (int i = 0; i < 12; i++) begin
            if (idx < 3) in_data = toks[idx];
            else begin in_valid = 0; ctl_valid = 0; core_valid = 0; end
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL release ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL release valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL release data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL release drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            if (obs_vld[1]) seen.push_back(obs_dat[WIDTH +: WIDTH]);
            if (exp_rdy[0]) idx++;
        end
        checks++;
        if (seen.size() != 3) begin
            errors++; $display("FAIL stall_count got=%0d exp=3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== toks[k]) begin
                    errors++; $display("FAIL stall_order idx=%0d got=%h exp=%h", k, seen[k], toks[k]);
                end
            end
        end
    endtask

    task automatic test_drop_saturate();
        idle_inputs();
        in_valid = 1; ctl_valid = 1; core_valid = 1; ctl_sel = 3; core_sel = 0;
        for (int i = 0; i < 301; i++) begin
            if (i == 300) begin in_valid = 0; ctl_valid = 0; core_valid = 0; end
            in_data = WIDTH'($urandom);
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL drop ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL drop valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL drop data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL drop drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
        end
        checks++;
        if (obs_drop !== 8'd255) begin
            errors++; $display("FAIL drop_saturate got=%0d exp=255", obs_drop);
        end
    endtask

    task automatic test_full_push_pop();
        idle_inputs();
        out_ready = 3'b110;
        in_valid = 1; ctl_valid = 1; core_valid = 1; ctl_sel = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) out_ready = 3'b111;
            if (i >= 5) begin in_valid = 0; ctl_valid = 0; core_valid = 0; end
            in_data = WIDTH'(11'h010 + i);
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL fullpp ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL fullpp valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL fullpp data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL fullpp drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            if (i >= 2 && i < 5) begin
                checks++;
                if (mq[0].size() != DEPTH || obs_rdy !== 3'b111) begin
                    errors++; $display("FAIL fullpp_occupancy cycle=%0d ready=%b model=%0d", i, obs_rdy, mq[0].size());
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            ctl_valid  = ($urandom_range(0, 3) != 0);
            core_valid = ($urandom_range(0, 3) != 0);
            ctl_sel    = SEL_W'($urandom);
            core_sel   = ($urandom_range(0, 3) == 0);
            in_data    = WIDTH'($urandom);
            out_ready  = NUM_OUT'($urandom);
            core_out_ready = $urandom_range(0, 1);
            if (i >= 590) begin idle_inputs(); reset = 0; end
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL random ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL random valid cyc=%0d got=%b exp=%b", i, obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL random data cyc=%0d got=%h exp=%h", i, obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL random drop_cnt cyc=%0d got=%0d exp=%0d", i, obs_drop, exp_drop); end
        end
        reset = 0;
    endtask

    task automatic test_reset_mid();
        logic [SEL_W-1:0] sels [4];
        logic             cores [4];
        sels[0] = 0; sels[1] = 2; sels[2] = 1; sels[3] = 3;
        cores[0] = 0; cores[1] = 0; cores[2] = 1; cores[3] = 0;
        idle_inputs();
        out_ready = '0; core_out_ready = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 4) begin
                in_valid = 1; ctl_valid = 1; core_valid = 1;
                ctl_sel = sels[i]; core_sel = cores[i]; in_data = WIDTH'(11'h500 + i);
            end else if (i == 4) begin
                reset = 1;
            end else begin
                reset = 0; in_valid = 0; ctl_valid = 0; core_valid = 0;
                out_ready = '1; core_out_ready = 1;
            end
            tick();
            checks += 4;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rstmid ready got=%b exp=%b", obs_rdy, exp_rdy); end
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL rstmid valid got=%b exp=%b", obs_vld, exp_vld); end
            if (obs_dat !== exp_dat) begin errors++; $display("FAIL rstmid data got=%h exp=%h", obs_dat, exp_dat); end
            if (obs_drop !== exp_drop) begin errors++; $display("FAIL rstmid drop_cnt got=%0d exp=%0d", obs_drop, exp_drop); end
            if (i == 4) begin
                checks++;
                if (obs_vld !== 4'b1101) begin
                    errors++; $display("FAIL rstmid_loaded got=%b exp=1101", obs_vld);
                end
            end
            if (i >= 5) begin
                checks++;
                if (obs_vld !== '0 || obs_drop !== 8'd0) begin
                    errors++; $display("FAIL rstmid_cleared got_valid=%b got_drop=%0d exp=0", obs_vld, obs_drop);
                end
            end
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_port_route();
        test_core_route();
        test_stall();
        test_drop_saturate();
        test_full_push_pop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
